uart_rx_loader: RTL and testbench

UART_RX_LOADER -- requirements
Module: uart_rx_loader

---
 rtl/uart_rx_loader.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader.sv
// 8N1 UART receiver that streams a fixed-length configuration image into a
// byte-addressed sink, raising a sticky done flag once the image is complete.
module uart_rx_loader #(
  parameter int unsigned CLK_PER_TICK = 27,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned NUM_BYTES    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [5:0] byte_index,
  output logic       frame_err,
  output logic       load_done
);

  localparam int unsigned TICK_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int unsigned OS_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W  = 6;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_TICK - 1);
  localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state, state_next;

  logic              rx_meta, rx_sync;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;
  logic [OS_W-1:0]   os_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;

  logic os_clr_c, os_inc_c, shift_c, accept_c, ferr_c;

  // Two-flop synchronizer; idle-high reset value avoids a false start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick_c = (tick_cnt == TICK_LAST);

  // Tick prescaler, re-phased to the detected start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if ((state == IDLE && state_next == START) || tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    os_clr_c   = 1'b0;
    os_inc_c   = 1'b0;
    shift_c    = 1'b0;
    accept_c   = 1'b0;
    ferr_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) state_next = START;
      end
      START: begin
        if (tick_c) begin
          if (os_cnt == HALF_LAST) begin
            os_clr_c   = 1'b1;
            state_next = rx_sync ? IDLE : DATA;
          end else begin
            os_inc_c = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          if (os_cnt == OS_LAST) begin
            os_clr_c = 1'b1;
            shift_c  = 1'b1;
            if (bit_cnt == 3'd7) state_next = STOP;
          end else begin
            os_inc_c = 1'b1;
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          if (os_cnt == OS_LAST) begin
            os_clr_c = 1'b1;
            if (rx_sync) begin
              accept_c   = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_c     = 1'b1;
              state_next = WAIT_IDLE;
            end
          end else begin
            os_inc_c = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Oversample/bit counters and LSB-first shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (os_clr_c)      os_cnt <= '0;
      else if (os_inc_c) os_cnt <= os_cnt + OS_W'(1);
      if (shift_c) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Output strobes and load addressing; index saturates at the last slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_index <= '0;
      frame_err  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      byte_valid <= accept_c && !load_done;
      frame_err  <= ferr_c;
      if (accept_c) byte_data <= shreg;
      if (byte_valid) begin
        if (byte_index == IDX_LAST) load_done  <= 1'b1;
        else                        byte_index <= byte_index + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench: a default-timing instance checks absolute latency and glitch
// rejection; a fast-tick instance covers framing, full loads and reset abort.
module tb_uart_rx_loader;

  localparam int unsigned OS    = 16;
  localparam int unsigned F_CPT = 3;
  localparam int unsigned BIT_F = F_CPT * OS;
  localparam int unsigned BIT_U = 27 * OS;
  localparam int unsigned LAT_U = (OS / 2 + 9 * OS) * 27 + 2;
  localparam int unsigned NB    = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  logic [7:0] byte_data,  u_byte_data;
  logic       byte_valid, u_byte_valid;
  logic [5:0] byte_index, u_byte_index;
  logic       frame_err,  u_frame_err;
  logic       load_done,  u_load_done;

  uart_rx_loader #(.CLK_PER_TICK(F_CPT), .OVERSAMPLE(OS), .NUM_BYTES(NB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_index(byte_index),
    .frame_err(frame_err), .load_done(load_done)
  );

  uart_rx_loader u_full (
    .clk(clk), .rst(rst), .rx(rx),
    .byte_data(u_byte_data), .byte_valid(u_byte_valid), .byte_index(u_byte_index),
    .frame_err(u_frame_err), .load_done(u_load_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe recorders: {index, data} per byte_valid, plus frame error counts.
  logic [13:0] fq[$];
  logic [13:0] uq[$];
  int f_ferr = 0, u_ferr = 0, u_tv = 0;

  always @(negedge clk) begin
    if (byte_valid) fq.push_back({byte_index, byte_data});
    if (frame_err) f_ferr++;
    if (byte_valid || frame_err) check("f_excl", 32'(byte_valid & frame_err), 0);
    if (u_byte_valid) begin
      uq.push_back({u_byte_index, u_byte_data});
      u_tv = cyc;
    end
    if (u_frame_err) u_ferr++;
    if (u_byte_valid || u_frame_err) check("u_excl", 32'(u_byte_valid & u_frame_err), 0);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    fq.delete();
    uq.delete();
    f_ferr = 0;
    u_ferr = 0;
  endtask

  // t0 is the cycle count after the first edge that samples the start bit.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int bitclk, output int t0);
    @(posedge clk); #1;
    rx = 1'b0;
    t0 = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      repeat (bitclk) @(posedge clk);
      #1 rx = d[i];
    end
    repeat (bitclk) @(posedge clk);
    #1 rx = stop;
    repeat (bitclk) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  function automatic logic [13:0] entry(input int n, input logic [13:0] q[$]);
    return (n < q.size()) ? q[n] : 14'h3fff;
  endfunction

  initial begin
    int t0;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(byte_data), 0);
    check("rst_valid", 32'(byte_valid), 0);
    check("rst_index", 32'(byte_index), 0);
    check("rst_ferr",  32'(frame_err), 0);
    check("rst_done",  32'(load_done), 0);
    check("rst_udone", 32'(u_load_done), 0);

    // Default timing: 0xA5 and its start-to-strobe latency.
    do_reset();
    send_byte(8'hA5, 1'b1, BIT_U, t0);
    repeat (20) @(posedge clk);
    #1;
    check("a5_count", uq.size(), 1);
    check("a5_entry", 32'(entry(0, uq)), 32'({6'd0, 8'hA5}));
    check("a5_lat",   u_tv - t0, LAT_U);
    check("a5_ferr",  u_ferr, 0);

    // Default timing: 100-clock low glitch rejected, then 0xFF accepted.
    do_reset();
    @(posedge clk); #1 rx = 1'b0;
    repeat (100) @(posedge clk);
    #1 rx = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    check("gl_count", uq.size(), 0);
    check("gl_ferr",  u_ferr, 0);
    send_byte(8'hFF, 1'b1, BIT_U, t0);
    repeat (20) @(posedge clk);
    #1;
    check("ff_count", uq.size(), 1);
    check("ff_entry", 32'(entry(0, uq)), 32'({6'd0, 8'hFF}));

    // Bad stop bit, then a good byte still lands at index 0.
    do_reset();
    send_byte(8'h3C, 1'b0, BIT_F, t0);
    repeat (10) @(posedge clk);
    #1;
    check("fe_ferr",  f_ferr, 1);
    check("fe_count", fq.size(), 0);
    send_byte(8'h01, 1'b1, BIT_F, t0);
    repeat (10) @(posedge clk);
    #1;
    check("fe_next_count", fq.size(), 1);
    check("fe_next_entry", 32'(entry(0, fq)), 32'({6'd0, 8'h01}));
    check("fe_ferr_once",  f_ferr, 1);

    // Full image load, then a surplus byte.
    do_reset();
    for (int i = 0; i < NB; i++) send_byte(8'(i), 1'b1, BIT_F, t0);
    repeat (10) @(posedge clk);
    #1;
    check("ld_count", fq.size(), NB);
    for (int i = 0; i < NB; i++)
      check("ld_entry", 32'(entry(i, fq)), 32'({6'(i), 8'(i)}));
    check("ld_done", 32'(load_done), 1);
    fq.delete();
    send_byte(8'h77, 1'b1, BIT_F, t0);
    repeat (10) @(posedge clk);
    #1;
    check("ov_count", fq.size(), 0);
    check("ov_data",  32'(byte_data), 32'h77);
    check("ov_index", 32'(byte_index), NB - 1);
    check("ov_done",  32'(load_done), 1);

    // Reset in the middle of bit 4 aborts the byte and clears load_done.
    d = 8'hC3;
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (BIT_F) @(posedge clk);
      #1 rx = d[i];
    end
    repeat (BIT_F) @(posedge clk);
    #1 rx = d[4];
    repeat (BIT_F / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    check("ra_done",  32'(load_done), 0);
    check("ra_index", 32'(byte_index), 0);
    fq.delete();
    f_ferr = 0;
    repeat (3 * BIT_F) @(posedge clk);
    send_byte(8'h5A, 1'b1, BIT_F, t0);
    repeat (10) @(posedge clk);
    #1;
    check("ra_count", fq.size(), 1);
    check("ra_entry", 32'(entry(0, fq)), 32'({6'd0, 8'h5A}));
    check("ra_ferr",  f_ferr, 0);

    // Back-to-back frames with a single stop bit.
    do_reset();
    send_byte(8'h12, 1'b1, BIT_F, t0);
    send_byte(8'h34, 1'b1, BIT_F, t0);
    repeat (10) @(posedge clk);
    #1;
    check("bb_count", fq.size(), 2);
    check("bb_entry0", 32'(entry(0, fq)), 32'({6'd0, 8'h12}));
    check("bb_entry1", 32'(entry(1, fq)), 32'({6'd1, 8'h34}));
    check("bb_ferr", f_ferr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
